// File: rtl/pmem_line_adapter.sv
// pmem_line_adapter
//
// Serves one 128-bit cache line request from the pmem_* interface as eight
// sequential 16-bit accesses to a word-wide synchronous SRAM. When the
// transfer completes it issues a single-cycle pmem_resp.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   pmem_address   line byte address; bits [3:0] ignored
//   pmem_read      line read request (level, held until pmem_resp)
//   pmem_write     line write request (level, held until pmem_resp); wins over read
//   pmem_wdata     write line, word k = [16k+15:16k]
//   pmem_rdata     line buffer; read data valid in the pmem_resp cycle of a read
//   pmem_resp      one-cycle completion pulse
//   sram_addr      SRAM word address (0 when no strobe)
//   sram_re        SRAM read strobe; data returns on sram_rdata the next cycle
//   sram_we        SRAM write strobe
//   sram_wdata     SRAM write word (0 when sram_we is low)
//   sram_rdata     SRAM read word
module pmem_line_adapter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [14:0]  sram_addr,
  output logic         sram_re,
  output logic         sram_we,
  output logic [15:0]  sram_wdata,
  input  logic [15:0]  sram_rdata
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  state_e        state_q, state_d;
  logic [11:0]   base_q, base_d;
  logic [127:0]  line_q, line_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [2:0]    cap_word;
  logic [6:0]    wr_lsb;
  logic [6:0]    cap_lsb;
  logic          strobe;

  // Byte offset within the line has no meaning for a whole-line transfer.
  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^pmem_address[3:0];

  // Read data lags the strobe by one cycle, so the word landing while cnt=k
  // belongs to slot k-1 (cnt=8 wraps the 3-bit slot to 7).
  assign cap_word = cnt_q[2:0] - 3'd1;
  assign wr_lsb   = {cnt_q[2:0], 4'b0000};
  assign cap_lsb  = {cap_word, 4'b0000};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pmem_write) begin
          base_d  = pmem_address[15:4];
          line_d  = pmem_wdata;
          cnt_d   = 4'd0;
          state_d = StWrite;
        end else if (pmem_read) begin
          base_d  = pmem_address[15:4];
          cnt_d   = 4'd0;
          state_d = StRead;
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = StResp;
        end
      end
      StRead: begin
        if (cnt_q != 4'd0) begin
          line_d[cap_lsb +: 16] = sram_rdata;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs: everything decodes from registered state only.
  always_comb begin
    pmem_rdata = line_q;
    pmem_resp  = (state_q == StResp);
    sram_we    = (state_q == StWrite);
    sram_re    = (state_q == StRead) && !cnt_q[3];
    strobe     = sram_we || sram_re;
    sram_addr  = '0;
    sram_wdata = '0;
    if (strobe) begin
      sram_addr = {base_q, cnt_q[2:0]};
    end
    if (sram_we) begin
      sram_wdata = line_q[wr_lsb +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pmem_line_adapter.sv
module tb_pmem_line_adapter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [14:0]  sram_addr;
  logic         sram_re;
  logic         sram_we;
  logic [15:0]  sram_wdata;
  logic [15:0]  sram_rdata;

  always #5 clk = ~clk;

  pmem_line_adapter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .sram_addr    (sram_addr),
    .sram_re      (sram_re),
    .sram_we      (sram_we),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous word SRAM (environment) plus an independent shadow copy the
  // model keeps from its own view of what must have been written.
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  function automatic logic [15:0] init_word(input int i);
    if (i >= 'h90 && i <= 'h97) return 16'(16'h1000 + (i - 'h90));
    return 16'(i * 3 + 7);
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  // Transaction-level model: kind 0 idle, 1 write, 2 read; t = cycles since
  // the accept cycle (cycle 0). Outputs follow from the timing rules.
  int           m_kind = 0;
  int           m_t    = 0;
  logic [11:0]  m_base = '0;
  logic [127:0] m_line = '0;
  longint       cyc    = 0;

  always @(posedge clk) begin
    cyc++;
    if (m_kind == 1 && m_t >= 1 && m_t <= 8)
      ref_mem[{m_base, 3'(m_t - 1)}] = m_line[(m_t - 1) * 16 +: 16];
    if (!reset_n) begin
      m_kind = 0;
      m_t    = 0;
      m_base = '0;
      m_line = '0;
    end else if (m_kind == 0) begin
      if (pmem_write) begin
        m_kind = 1; m_t = 1; m_base = pmem_address[15:4]; m_line = pmem_wdata;
      end else if (pmem_read) begin
        m_kind = 2; m_t = 1; m_base = pmem_address[15:4];
      end
    end else if ((m_kind == 1 && m_t == 9) || (m_kind == 2 && m_t == 10)) begin
      m_kind = 0;
      m_t    = 0;
    end else begin
      if (m_kind == 2 && m_t == 9)
        for (int k = 0; k < 8; k++) m_line[k * 16 +: 16] = ref_mem[{m_base, 3'(k)}];
      m_t++;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic        e_we, e_re, e_resp;
      logic [14:0] e_addr;
      logic [15:0] e_wd;
      e_we   = (m_kind == 1) && m_t >= 1 && m_t <= 8;
      e_re   = (m_kind == 2) && m_t >= 1 && m_t <= 8;
      e_resp = (m_kind == 1 && m_t == 9) || (m_kind == 2 && m_t == 10);
      e_addr = (e_we || e_re) ? {m_base, 3'(m_t - 1)} : 15'd0;
      e_wd   = e_we ? m_line[(m_t - 1) * 16 +: 16] : 16'd0;
      chk("sram_we", sram_we, e_we);
      chk("sram_re", sram_re, e_re);
      chk("pmem_resp", pmem_resp, e_resp);
      chk("sram_addr", sram_addr, e_addr);
      chk("sram_wdata", sram_wdata, e_wd);
      if (!(m_kind == 2 && m_t < 10)) chk("pmem_rdata", pmem_rdata, m_line);
    end
  end

  // Directed transfer driver; called at a negedge in an IDLE cycle (cycle 0).
  logic [14:0] log_addr [0:15];
  logic [15:0] log_wd   [0:15];
  int          n_re, n_we, resp_cyc;
  longint      resp_abs;

  task automatic xfer(input logic w, input logic r, input logic [15:0] a,
                      input logic [127:0] wd, input bit scramble);
    pmem_write = w; pmem_read = r; pmem_address = a; pmem_wdata = wd;
    n_re = 0; n_we = 0; resp_cyc = -1; resp_abs = 0;
    for (int c = 1; c <= 24 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (sram_re && n_re < 16) begin log_addr[n_re] = sram_addr; n_re++; end
      if (sram_we && n_we < 16) begin
        log_addr[n_we] = sram_addr; log_wd[n_we] = sram_wdata; n_we++;
      end
      if (scramble && c >= 2 && c <= 7) begin
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (pmem_resp) begin
        resp_cyc = c; resp_abs = cyc;
        pmem_write = 1'b0; pmem_read = 1'b0;
      end
    end
    if (resp_cyc < 0) chk("resp_timeout", 1'b0, 1'b1);
  endtask

  logic [127:0] a_line;
  longint       first_resp;

  initial begin
    reset_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", pmem_rdata, 128'd0);
    chk("rst_resp", pmem_resp, 1'b0);
    chk("rst_strobes", {sram_re, sram_we}, 2'b00);
    chk("rst_addr", sram_addr, 15'd0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(negedge clk);

    // Read fill
    xfer(1'b0, 1'b1, 16'h0120, '0, 1'b0);
    chk("fill_resp_cyc", resp_cyc, 10);
    chk("fill_n_re", n_re, 8);
    for (int k = 0; k < 8; k++) chk("fill_addr", log_addr[k], 15'(16'h0090 + k));
    chk("fill_rdata", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    @(negedge clk);

    // Unaligned read
    xfer(1'b0, 1'b1, 16'h012A, '0, 1'b0);
    for (int k = 0; k < 8; k++) chk("unal_addr", log_addr[k], 15'(16'h0090 + k));
    chk("unal_rdata", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    @(negedge clk);

    // Line write, then the requester switches to a fill on the resp edge
    for (int k = 0; k < 8; k++) a_line[k * 16 +: 16] = 16'(16'hA000 + k);
    xfer(1'b1, 1'b0, 16'h0340, a_line, 1'b0);
    chk("wr_resp_cyc", resp_cyc, 9);
    chk("wr_n_we", n_we, 8);
    chk("wr_n_re", n_re, 0);
    for (int k = 0; k < 8; k++) begin
      chk("wr_addr", log_addr[k], 15'(16'h01A0 + k));
      chk("wr_data", log_wd[k], 16'(16'hA000 + k));
    end
    first_resp = resp_abs;
    xfer(1'b0, 1'b1, 16'h0340, '0, 1'b0);
    chk("wbf_n_re", n_re, 8);
    chk("wbf_n_we", n_we, 0);
    chk("wbf_gap", resp_abs - first_resp, 11);
    chk("wbf_rdata", pmem_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    @(negedge clk);

    // Priority: both asserted gives only a write
    for (int k = 0; k < 8; k++) a_line[k * 16 +: 16] = 16'(16'h5500 + k);
    xfer(1'b1, 1'b1, 16'h0800, a_line, 1'b0);
    chk("prio_n_re", n_re, 0);
    chk("prio_n_we", n_we, 8);
    chk("prio_resp_cyc", resp_cyc, 9);
    @(negedge clk);

    // Hold stability: inputs churn mid-write
    for (int k = 0; k < 8; k++) a_line[k * 16 +: 16] = 16'(16'hB000 + k);
    xfer(1'b1, 1'b0, 16'h0500, a_line, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("hold_addr", log_addr[k], 15'(16'h0280 + k));
      chk("hold_data", log_wd[k], 16'(16'hB000 + k));
    end
    @(negedge clk);

    // Reset in cycle 5 of a read
    pmem_read = 1'b1; pmem_address = 16'h0120;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    pmem_read = 1'b0;
    @(negedge clk);
    chk("mrst_rdata", pmem_rdata, 128'd0);
    chk("mrst_outs", {pmem_resp, sram_re, sram_we}, 3'b000);
    chk("mrst_addr", {sram_addr, sram_wdata}, 31'd0);
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("mrst_no_resp", pmem_resp, 1'b0);
    end
    xfer(1'b0, 1'b1, 16'h0120, '0, 1'b0);
    chk("mrst_resp_cyc", resp_cyc, 10);
    chk("mrst_rdata2", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
